// File: rtl/cim_mem_arbiter.sv
// Single-port temp-result SRAM arbiter for the CIM datapath: one grant per cycle,
// lowest-index priority, writes win over reads, fixed two-cycle read return.
module cim_mem_arbiter #(
    parameter int NUM_SRC = 7,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              read_req_src,
    input  logic [NUM_SRC-1:0]              write_req_src,
    input  logic [NUM_SRC-1:0][ADDR_W-1:0]  addr_table,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]  write_data,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_valid,
    output logic [NUM_SRC-1:0]              rd_src,
    input  logic                            err_clr,
    output logic                            err_multi_hot,
    output logic                            err_rw_collision
);

    function automatic logic [NUM_SRC-1:0] lowest_bit(input logic [NUM_SRC-1:0] req);
        return req & (~req + NUM_SRC'(1));
    endfunction

    function automatic logic is_multi_hot(input logic [NUM_SRC-1:0] req);
        return (req & (req - NUM_SRC'(1))) != '0;
    endfunction

    logic               wr_any;
    logic               rd_any;
    logic               rd_grant;
    logic               multi_err;
    logic               coll_err;
    logic [NUM_SRC-1:0] wr_sel;
    logic [NUM_SRC-1:0] rd_sel;
    logic [NUM_SRC-1:0] sel;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_wdata;

    logic               vld_p0;
    logic [NUM_SRC-1:0] src_p0;
    logic               vld_p1;
    logic [NUM_SRC-1:0] src_p1;

    always_comb begin
        wr_any      = |write_req_src;
        rd_any      = |read_req_src;
        wr_sel      = lowest_bit(write_req_src);
        rd_sel      = lowest_bit(read_req_src);
        sel         = wr_any ? wr_sel : rd_sel;
        rd_grant    = rd_any && !wr_any;
        multi_err   = is_multi_hot(read_req_src) || is_multi_hot(write_req_src);
        coll_err    = rd_any && wr_any;
        grant_addr  = '0;
        grant_wdata = '0;
        // sel is one-hot, so an AND-OR mux picks exactly one entry
        for (int i = 0; i < NUM_SRC; i++) begin
            grant_addr  = grant_addr  | (addr_table[i] & {ADDR_W{sel[i]}});
            grant_wdata = grant_wdata | (write_data[i] & {DATA_W{wr_sel[i]}});
        end
    end

    // Stage p0: grant registered onto the SRAM port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            vld_p0    <= 1'b0;
            src_p0    <= '0;
        end else begin
            mem_en <= wr_any || rd_any;
            mem_we <= wr_any;
            vld_p0 <= rd_grant;
            src_p0 <= rd_grant ? rd_sel : '0;
            if (wr_any || rd_any) begin
                mem_addr <= grant_addr;
            end
            if (wr_any) begin
                mem_wdata <= grant_wdata;
            end
        end
    end

    // Stage p1: tag aligned with the SRAM's registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            src_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            src_p1 <= src_p0;
        end
    end

    // A new error in the same cycle as err_clr wins over the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_multi_hot    <= 1'b0;
            err_rw_collision <= 1'b0;
        end else begin
            err_multi_hot    <= multi_err || (err_multi_hot && !err_clr);
            err_rw_collision <= coll_err || (err_rw_collision && !err_clr);
        end
    end

    assign rd_valid = vld_p1;
    assign rd_src   = src_p1;
    assign rd_data  = mem_rdata;

endmodule

// File: tb/tb_cim_mem_arbiter.sv
// Directed bench for cim_mem_arbiter with a behavioural synchronous SRAM model.
module tb_cim_mem_arbiter;

    localparam int NUM_SRC = 7;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 16;

    logic                           clk = 1'b0;
    logic                           rst = 1'b0;
    logic [NUM_SRC-1:0]             read_req_src = '0;
    logic [NUM_SRC-1:0]             write_req_src = '0;
    logic [NUM_SRC-1:0][ADDR_W-1:0] addr_table = '0;
    logic [NUM_SRC-1:0][DATA_W-1:0] write_data = '0;
    logic                           mem_en;
    logic                           mem_we;
    logic [ADDR_W-1:0]              mem_addr;
    logic [DATA_W-1:0]              mem_wdata;
    logic [DATA_W-1:0]              mem_rdata = '0;
    logic [DATA_W-1:0]              rd_data;
    logic                           rd_valid;
    logic [NUM_SRC-1:0]             rd_src;
    logic                           err_clr = 1'b0;
    logic                           err_multi_hot;
    logic                           err_rw_collision;

    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];

    int n_chk = 0;
    int n_err = 0;

    cim_mem_arbiter #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .read_req_src(read_req_src), .write_req_src(write_req_src),
        .addr_table(addr_table), .write_data(write_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid), .rd_src(rd_src),
        .err_clr(err_clr), .err_multi_hot(err_multi_hot), .err_rw_collision(err_rw_collision)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        read_req_src  = '0;
        write_req_src = '0;
        err_clr       = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_en"},   32'(mem_en), 0);
        chk_eq({tag, "_we"},   32'(mem_we), 0);
        chk_eq({tag, "_addr"}, 32'(mem_addr), 0);
        chk_eq({tag, "_wd"},   32'(mem_wdata), 0);
        chk_eq({tag, "_rv"},   32'(rd_valid), 0);
        chk_eq({tag, "_rs"},   32'(rd_src), 0);
        chk_eq({tag, "_emh"},  32'(err_multi_hot), 0);
        chk_eq({tag, "_erc"},  32'(err_rw_collision), 0);
    endtask

    logic [ADDR_W-1:0] s_addr [0:6];
    logic [DATA_W-1:0] s_data [0:6];

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = '0;
        s_addr = '{11'h005, 11'h010, 11'h030, 11'h040, 11'h005, 11'h010, 11'h030};
        s_data = '{16'h1234, 16'hBEEF, 16'hCAFE, 16'h1111, 16'h1234, 16'hBEEF, 16'hCAFE};

        // Reset state, requests ignored while rst is high
        #1 rst = 1'b1;
        #1 chk_all_zero("reset");
        write_req_src = 7'b0000010;
        addr_table[1] = 11'h040;
        write_data[1] = 16'h1111;
        step();
        step();
        chk_eq("rst_ignore_en", 32'(mem_en), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk_eq("first_grant_en",   32'(mem_en), 1);
        chk_eq("first_grant_we",   32'(mem_we), 1);
        chk_eq("first_grant_addr", 32'(mem_addr), 32'h040);
        chk_eq("first_grant_wd",   32'(mem_wdata), 32'h1111);
        idle_reqs();
        step();
        chk_eq("idle_en", 32'(mem_en), 0);
        chk_eq("idle_we", 32'(mem_we), 0);

        // Write then read-after-write from a different source
        write_req_src = 7'b0000100;
        addr_table[2] = 11'h005;
        write_data[2] = 16'h1234;
        step();
        chk_eq("wr_en",   32'(mem_en), 1);
        chk_eq("wr_we",   32'(mem_we), 1);
        chk_eq("wr_addr", 32'(mem_addr), 32'h005);
        chk_eq("wr_wd",   32'(mem_wdata), 32'h1234);
        idle_reqs();
        read_req_src  = 7'b0010000;
        addr_table[4] = 11'h005;
        step();
        idle_reqs();
        chk_eq("rd_en",   32'(mem_en), 1);
        chk_eq("rd_we",   32'(mem_we), 0);
        chk_eq("rd_addr", 32'(mem_addr), 32'h005);
        chk_eq("rd_wd_hold", 32'(mem_wdata), 32'h1234);
        chk_eq("rd_k1_rv", 32'(rd_valid), 0);
        step();
        chk_eq("rd_rv",   32'(rd_valid), 1);
        chk_eq("rd_src",  32'(rd_src), 32'b0010000);
        chk_eq("rd_data", 32'(rd_data), 32'h1234);
        step();
        chk_eq("rd_after_rv",  32'(rd_valid), 0);
        chk_eq("rd_after_src", 32'(rd_src), 0);

        // Multi-hot read: lowest index wins, flag sticky until err_clr
        write_req_src = 7'b0001000;
        addr_table[3] = 11'h010;
        write_data[3] = 16'hBEEF;
        step();
        idle_reqs();
        read_req_src  = 7'b0100010;
        addr_table[1] = 11'h010;
        addr_table[5] = 11'h020;
        step();
        idle_reqs();
        chk_eq("mh_flag", 32'(err_multi_hot), 1);
        chk_eq("mh_addr", 32'(mem_addr), 32'h010);
        step();
        chk_eq("mh_rv",   32'(rd_valid), 1);
        chk_eq("mh_src",  32'(rd_src), 32'b0000010);
        chk_eq("mh_data", 32'(rd_data), 32'hBEEF);
        step();
        step();
        chk_eq("mh_sticky", 32'(err_multi_hot), 1);
        chk_eq("mh_no_coll", 32'(err_rw_collision), 0);
        err_clr = 1'b1;
        step();
        idle_reqs();
        chk_eq("mh_cleared", 32'(err_multi_hot), 0);

        // Collision: write wins, read dropped
        write_req_src = 7'b0000001;
        read_req_src  = 7'b1000000;
        addr_table[0] = 11'h030;
        write_data[0] = 16'hCAFE;
        addr_table[6] = 11'h010;
        step();
        idle_reqs();
        chk_eq("col_we",   32'(mem_we), 1);
        chk_eq("col_addr", 32'(mem_addr), 32'h030);
        chk_eq("col_wd",   32'(mem_wdata), 32'hCAFE);
        chk_eq("col_flag", 32'(err_rw_collision), 1);
        chk_eq("col_no_mh", 32'(err_multi_hot), 0);
        step();
        chk_eq("col_rv1", 32'(rd_valid), 0);
        step();
        chk_eq("col_rv2", 32'(rd_valid), 0);
        chk_eq("col_sticky", 32'(err_rw_collision), 1);

        // Clear coincident with a new multi-hot error keeps that flag set
        err_clr       = 1'b1;
        read_req_src  = 7'b0000011;
        addr_table[0] = 11'h005;
        step();
        idle_reqs();
        chk_eq("clr_new_mh",  32'(err_multi_hot), 1);
        chk_eq("clr_coll",    32'(err_rw_collision), 0);
        step();
        chk_eq("clr_new_src", 32'(rd_src), 32'b0000001);
        chk_eq("clr_new_dat", 32'(rd_data), 32'h1234);
        err_clr = 1'b1;
        step();
        idle_reqs();
        chk_eq("clr_mh_done", 32'(err_multi_hot), 0);

        // Reset while a read is in flight
        read_req_src  = 7'b0000100;
        addr_table[2] = 11'h005;
        step();
        idle_reqs();
        chk_eq("rmr_en_before", 32'(mem_en), 1);
        rst = 1'b1;
        #1 chk_all_zero("rmr");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_eq("rmr_no_rv", 32'(rd_valid), 0);
        end

        // Streaming reads from sources 0..6
        for (int c = 0; c < 9; c++) begin
            idle_reqs();
            if (c < 7) begin
                read_req_src  = 7'(1 << c);
                addr_table[c] = s_addr[c];
            end
            step();
            if (c >= 1 && c <= 7) begin
                chk_eq("str_rv",   32'(rd_valid), 1);
                chk_eq("str_src",  32'(rd_src), 32'(1 << (c - 1)));
                chk_eq("str_data", 32'(rd_data), 32'(s_data[c - 1]));
            end else if (c == 8) begin
                chk_eq("str_end_rv",  32'(rd_valid), 0);
                chk_eq("str_end_src", 32'(rd_src), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
